// File: rtl/serial_slave_mem.sv
// serial_slave_mem: bit-serial memory slave for a serial_bus slave port.
// The address and write data arrive LSB first. Words are held in a register
// file, and read data is serialised back LSB first. When SPLIT_EN is set, every
// read releases the bus for SPLIT_LATENCY cycles and then waits for split_grant.
module serial_slave_mem #(
    parameter int ADDR_WIDTH     = 12,
    parameter int DATA_WIDTH     = 8,
    parameter int MEM_ADDR_WIDTH = 8,
    parameter int READ_LATENCY   = 1,
    parameter int SPLIT_EN       = 0,
    parameter int SPLIT_LATENCY  = 4
) (
    input  logic clk,
    input  logic rstn,
    input  logic swdata,
    input  logic swvalid,
    input  logic smode,
    output logic srdata,
    output logic srvalid,
    output logic sready,
    output logic ssplit,
    input  logic split_grant
);

    localparam int DEPTH   = 1 << MEM_ADDR_WIDTH;
    localparam int MAX_AD  = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
    localparam int MAX_LT  = (READ_LATENCY > SPLIT_LATENCY) ? READ_LATENCY : SPLIT_LATENCY;
    localparam int MAX_CNT = (MAX_AD > MAX_LT) ? MAX_AD : MAX_LT;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        ADDR       = 3'd1,
        WDATA      = 3'd2,
        WRITE      = 3'd3,
        RLAT       = 3'd4,
        SPLIT_WAIT = 3'd5,
        SPLIT_REQ  = 3'd6,
        RDATA      = 3'd7
    } state_t;

    logic [DATA_WIDTH-1:0]     mem_r [DEPTH];
    state_t                    state_r;
    logic [CNT_W-1:0]          cnt_r;
    logic                      mode_r;
    logic [MEM_ADDR_WIDTH-1:0] idx_r;
    logic [DATA_WIDTH-1:0]     wdata_r;
    logic [DATA_WIDTH-1:0]     rd_word_r;
    logic                      sready_r;
    logic                      srvalid_r;
    logic                      srdata_r;
    logic                      ssplit_r;

    logic [DATA_WIDTH-1:0]     mem_rd_s;
    logic                      first_bit_s;
    logic                      mode_cur_s;
    logic                      last_addr_s;
    logic                      last_data_s;
    logic                      lat_done_s;
    logic                      split_done_s;
    logic                      rd_done_s;

    // Select bit i of a word. A compare loop is used here instead of a
    // variable index, so the counter width does not have to match the word.
    function automatic logic bit_at(input logic [DATA_WIDTH-1:0] w,
                                    input logic [CNT_W-1:0] i);
        logic b;
        b = 1'b0;
        for (int k = 0; k < DATA_WIDTH; k++) begin
            if (i == CNT_W'(k)) begin
                b = w[k];
            end
        end
        return b;
    endfunction

    assign srdata  = srdata_r;
    assign srvalid = srvalid_r;
    assign sready  = sready_r;
    assign ssplit  = ssplit_r;

    // Memory read port and phase-end decodes derived from the bit counter.
    always_comb begin
        mem_rd_s     = mem_r[idx_r];
        // The first read cycle uses the array directly, because rd_word_r is still loading.
        first_bit_s  = (cnt_r == {CNT_W{1'b0}}) ? mem_rd_s[0] : rd_word_r[0];
        // smode counts only with the first address bit, so later values are not sampled.
        mode_cur_s   = (state_r == IDLE) ? smode : mode_r;
        last_addr_s  = (cnt_r == CNT_W'(ADDR_WIDTH - 1));
        last_data_s  = (cnt_r == CNT_W'(DATA_WIDTH - 1));
        lat_done_s   = (cnt_r == CNT_W'(READ_LATENCY - 1));
        split_done_s = (cnt_r == CNT_W'(SPLIT_LATENCY - 1));
        rd_done_s    = (cnt_r == CNT_W'(DATA_WIDTH));
    end

    // Transaction FSM: deserialise, sequence the latency or split, serialise read data.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r   <= IDLE;
            cnt_r     <= {CNT_W{1'b0}};
            mode_r    <= 1'b0;
            idx_r     <= {MEM_ADDR_WIDTH{1'b0}};
            wdata_r   <= {DATA_WIDTH{1'b0}};
            rd_word_r <= {DATA_WIDTH{1'b0}};
            sready_r  <= 1'b1;
            srvalid_r <= 1'b0;
            srdata_r  <= 1'b0;
            ssplit_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE, ADDR: begin
                    if (swvalid) begin
                        if (state_r == IDLE) begin
                            mode_r <= smode;
                        end
                        // Keep only the low index bits. Upper address bits alias.
                        for (int i = 0; i < MEM_ADDR_WIDTH; i++) begin
                            if (cnt_r == CNT_W'(i)) begin
                                idx_r[i] <= swdata;
                            end
                        end
                        if (last_addr_s) begin
                            cnt_r <= {CNT_W{1'b0}};
                            if (mode_cur_s) begin
                                state_r <= WDATA;
                            end else begin
                                sready_r <= 1'b0;
                                if (SPLIT_EN != 0) begin
                                    state_r  <= SPLIT_WAIT;
                                    ssplit_r <= 1'b1;
                                end else begin
                                    state_r <= RLAT;
                                end
                            end
                        end else begin
                            state_r <= ADDR;
                            cnt_r   <= cnt_r + CNT_W'(1);
                        end
                    end
                end
                WDATA: begin
                    if (swvalid) begin
                        for (int i = 0; i < DATA_WIDTH; i++) begin
                            if (cnt_r == CNT_W'(i)) begin
                                wdata_r[i] <= swdata;
                            end
                        end
                        if (last_data_s) begin
                            state_r  <= WRITE;
                            sready_r <= 1'b0;
                            cnt_r    <= {CNT_W{1'b0}};
                        end else begin
                            cnt_r <= cnt_r + CNT_W'(1);
                        end
                    end
                end
                WRITE: begin
                    state_r  <= IDLE;
                    sready_r <= 1'b1;
                end
                RLAT: begin
                    if (cnt_r == {CNT_W{1'b0}}) begin
                        rd_word_r <= mem_rd_s;
                    end
                    if (lat_done_s) begin
                        state_r   <= RDATA;
                        srvalid_r <= 1'b1;
                        srdata_r  <= first_bit_s;
                        cnt_r     <= CNT_W'(1);
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                SPLIT_WAIT: begin
                    if (cnt_r == {CNT_W{1'b0}}) begin
                        rd_word_r <= mem_rd_s;
                    end
                    if (split_done_s) begin
                        state_r  <= SPLIT_REQ;
                        ssplit_r <= 1'b0;
                        cnt_r    <= {CNT_W{1'b0}};
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                SPLIT_REQ: begin
                    if (split_grant) begin
                        state_r   <= RDATA;
                        srvalid_r <= 1'b1;
                        srdata_r  <= rd_word_r[0];
                        cnt_r     <= CNT_W'(1);
                    end
                end
                RDATA: begin
                    if (rd_done_s) begin
                        state_r   <= IDLE;
                        srvalid_r <= 1'b0;
                        srdata_r  <= 1'b0;
                        sready_r  <= 1'b1;
                        cnt_r     <= {CNT_W{1'b0}};
                    end else begin
                        srdata_r <= bit_at(rd_word_r, cnt_r);
                        cnt_r    <= cnt_r + CNT_W'(1);
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    cnt_r     <= {CNT_W{1'b0}};
                    sready_r  <= 1'b1;
                    srvalid_r <= 1'b0;
                    srdata_r  <= 1'b0;
                    ssplit_r  <= 1'b0;
                end
            endcase
        end
    end

    // Register-file write. A reset takes the FSM out of WRITE, so a partial write is never committed.
    always_ff @(posedge clk) begin
        if (state_r == WRITE) begin
            mem_r[idx_r] <= wdata_r;
        end
    end

endmodule

// File: tb/tb_serial_slave_mem.sv
// Testbench for serial_slave_mem. dut0 is a plain read slave (READ_LATENCY=1)
// and dut1 is a split slave (SPLIT_LATENCY=4). Both share the bus inputs, so
// both memories hold the same contents.
module tb_serial_slave_mem;

    logic clk = 1'b0;
    logic rstn;
    logic swdata, swvalid, smode, split_grant;
    logic srdata0, srvalid0, sready0, ssplit0;
    logic srdata1, srvalid1, sready1, ssplit1;

    int nvec = 0;
    int nerr = 0;

    logic [7:0] mem_m [256];
    int         written_q [$];

    typedef struct {
        logic       wr;
        logic [11:0] addr;
        logic [7:0] data;
        logic       gap;
        int         g;
        logic       pulses;
        logic [7:0] expw;
    } vec_t;

    vec_t tbl [9];

    always #5 clk = ~clk;

    serial_slave_mem #(.ADDR_WIDTH(12), .DATA_WIDTH(8), .MEM_ADDR_WIDTH(8),
                       .READ_LATENCY(1), .SPLIT_EN(0), .SPLIT_LATENCY(4)) dut0 (
        .clk(clk), .rstn(rstn), .swdata(swdata), .swvalid(swvalid), .smode(smode),
        .srdata(srdata0), .srvalid(srvalid0), .sready(sready0), .ssplit(ssplit0),
        .split_grant(split_grant));

    serial_slave_mem #(.ADDR_WIDTH(12), .DATA_WIDTH(8), .MEM_ADDR_WIDTH(8),
                       .READ_LATENCY(1), .SPLIT_EN(1), .SPLIT_LATENCY(4)) dut1 (
        .clk(clk), .rstn(rstn), .swdata(swdata), .swvalid(swvalid), .smode(smode),
        .srdata(srdata1), .srvalid(srvalid1), .sready(sready1), .ssplit(ssplit1),
        .split_grant(split_grant));

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int k, input logic [31:0] act,
                       input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, k, act, exp);
        end
    endtask

    // Each cycle in the loop presents one serial bit. With gap set, two idle
    // cycles come after every third bit.
    task automatic send_stream(input logic [19:0] bits, input int n, input logic mode,
                               input logic gap);
        for (int i = 0; i < n; i++) begin
            if (gap && i > 0 && (i % 3) == 0) begin
                repeat (2) begin
                    swvalid = 1'b0;
                    swdata  = 1'($urandom);
                    tick();
                end
            end
            chk("accept_sready", i, {30'd0, sready0, sready1}, 32'd3);
            swvalid = 1'b1;
            swdata  = bits[i];
            smode   = (i == 0) ? mode : 1'($urandom);
            tick();
        end
        swvalid = 1'b0;
    endtask

    task automatic do_write(input logic [11:0] addr, input logic [7:0] data, input logic gap);
        send_stream({data, addr}, 20, 1'b1, gap);
        chk("wr_busy_sready", 0, {30'd0, sready0, sready1}, 32'd0);
        tick();
        chk("wr_done_sready", 0, {30'd0, sready0, sready1}, 32'd3);
        mem_m[addr[7:0]] = data;
        written_q.push_back(int'(addr[7:0]));
    endtask

    // In the loop, k counts cycles after the last address bit (k=1 is T+1).
    task automatic do_read(input logic [11:0] addr, input logic [7:0] expw, input int g,
                           input logic pulses);
        logic [3:0] e0, e1;
        logic       v, d;
        logic [7:0] got0, got1;
        got0 = 8'd0;
        got1 = 8'd0;
        send_stream({8'd0, addr}, 12, 1'b0, 1'b0);
        for (int k = 1; k <= g + 9; k++) begin
            v  = (k >= 2 && k <= 9);
            d  = v ? expw[(k - 2) & 7] : 1'b0;
            e0 = {(k >= 10), 1'b0, v, d};
            v  = (k >= g + 1 && k <= g + 8);
            d  = v ? expw[(k - g - 1) & 7] : 1'b0;
            e1 = {(k >= g + 9), (k >= 1 && k <= 4), v, d};
            chk("rd0_rdy_spl_vld_dat", k, {28'd0, sready0, ssplit0, srvalid0, srdata0}, {28'd0, e0});
            chk("rd1_rdy_spl_vld_dat", k, {28'd0, sready1, ssplit1, srvalid1, srdata1}, {28'd0, e1});
            if (srvalid0) got0 = {srdata0, got0[7:1]};
            if (srvalid1) got1 = {srdata1, got1[7:1]};
            split_grant = (k == g) || (pulses && k == 2);
            swvalid     = pulses && (k <= 8) && ((k % 2) == 1);
            swdata      = 1'($urandom);
            smode       = 1'($urandom);
            tick();
        end
        split_grant = 1'b0;
        swvalid     = 1'b0;
        chk("rd0_word", 0, {24'd0, got0}, {24'd0, expw});
        chk("rd1_word", 0, {24'd0, got1}, {24'd0, expw});
    endtask

    initial begin
        int         idx;
        logic [11:0] a;
        logic [7:0] dw;

        tbl[0] = '{1'b1, 12'h003, 8'hA5, 1'b0, 0, 1'b0, 8'h00};
        tbl[1] = '{1'b0, 12'h003, 8'h00, 1'b0, 9, 1'b0, 8'hA5};
        tbl[2] = '{1'b1, 12'h010, 8'h3C, 1'b1, 0, 1'b0, 8'h00};
        tbl[3] = '{1'b0, 12'h010, 8'h00, 1'b0, 6, 1'b0, 8'h3C};
        tbl[4] = '{1'b0, 12'h110, 8'h00, 1'b0, 5, 1'b0, 8'h3C};
        tbl[5] = '{1'b1, 12'h020, 8'h5A, 1'b0, 0, 1'b0, 8'h00};
        tbl[6] = '{1'b0, 12'h020, 8'h00, 1'b0, 9, 1'b1, 8'h5A};
        tbl[7] = '{1'b1, 12'h0FF, 8'hFF, 1'b0, 0, 1'b0, 8'h00};
        tbl[8] = '{1'b0, 12'h0FF, 8'h00, 1'b0, 7, 1'b0, 8'hFF};

        rstn = 1'b0;
        swdata = 1'b0; swvalid = 1'b0; smode = 1'b0; split_grant = 1'b0;
        repeat (3) tick();
        chk("reset_dut0", 0, {28'd0, sready0, ssplit0, srvalid0, srdata0}, 32'h8);
        chk("reset_dut1", 0, {28'd0, sready1, ssplit1, srvalid1, srdata1}, 32'h8);
        rstn = 1'b1;
        tick();

        // Directed table: a write runs straight into the next transaction.
        for (int i = 0; i < 9; i++) begin
            if (tbl[i].wr) do_write(tbl[i].addr, tbl[i].data, tbl[i].gap);
            else           do_read(tbl[i].addr, tbl[i].expw, tbl[i].g, tbl[i].pulses);
        end

        // Reset in the middle of WDATA: the partial write must be discarded.
        send_stream({8'h00, 12'h003}, 16, 1'b1, 1'b0);
        #1;
        rstn = 1'b0;
        #1;
        chk("midrst_dut0", 0, {28'd0, sready0, ssplit0, srvalid0, srdata0}, 32'h8);
        chk("midrst_dut1", 0, {28'd0, sready1, ssplit1, srvalid1, srdata1}, 32'h8);
        tick();
        rstn = 1'b1;
        tick();
        do_read(12'h003, 8'hA5, 8, 1'b0);

        // split_grant pulses while idle must be ignored.
        for (int i = 0; i < 4; i++) begin
            split_grant = (i % 2 == 0);
            tick();
            chk("idle_grant_dut0", i, {28'd0, sready0, ssplit0, srvalid0, srdata0}, 32'h8);
            chk("idle_grant_dut1", i, {28'd0, sready1, ssplit1, srvalid1, srdata1}, 32'h8);
        end
        split_grant = 1'b0;
        do_read(12'h020, 8'h5A, 5, 1'b0);

        // Random traffic checked against the array model.
        for (int n = 0; n < 40; n++) begin
            if (written_q.size() == 0 || $urandom_range(0, 1) == 0) begin
                a  = 12'($urandom);
                dw = 8'($urandom);
                do_write(a, dw, 1'($urandom));
            end else begin
                idx = written_q[$urandom_range(0, written_q.size() - 1)];
                a   = {4'($urandom), 8'(idx)};
                do_read(a, mem_m[idx], $urandom_range(5, 12), 1'($urandom));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
